// File: rtl/step_motor_sequencer.sv
// Command-driven full/half-step phase sequencer for one bipolar stepper channel.
// It walks the AX/AY/BX/BY coil pattern at a programmed rate, tracks absolute position and drops the coils on driver FAULT.
module step_motor_sequencer #(
    parameter int PERIOD_W = 24,
    parameter int STEPS_W  = 16
) (
    input  logic                csi_MCLK_clk,
    input  logic                rsi_MRST_reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_dir,
    input  logic [STEPS_W-1:0]  cmd_steps,
    input  logic [PERIOD_W-1:0] cmd_period,
    input  logic                half_step,
    input  logic                hold_en,
    input  logic                abort,
    input  logic                fault_n,
    input  logic                fault_clear,
    output logic                AX,
    output logic                AY,
    output logic                BX,
    output logic                BY,
    output logic                busy,
    output logic                done,
    output logic                fault,
    output logic [STEPS_W-1:0]  steps_left,
    output logic signed [31:0]  position
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    // Coil pattern {AX,AY,BX,BY} for each table index.
    function automatic logic [3:0] phase_of(input logic [2:0] idx);
        logic [3:0] pat;
        case (idx)
            3'd0:    pat = 4'b1000;
            3'd1:    pat = 4'b1010;
            3'd2:    pat = 4'b0010;
            3'd3:    pat = 4'b0110;
            3'd4:    pat = 4'b0100;
            3'd5:    pat = 4'b0101;
            3'd6:    pat = 4'b0001;
            default: pat = 4'b1001;
        endcase
        return pat;
    endfunction

    state_t               state_q, state_d;
    logic [2:0]           idx_q, idx_d;
    logic signed [31:0]   pos_q, pos_d;
    logic [STEPS_W-1:0]   steps_q, steps_d;
    logic [PERIOD_W-1:0]  cnt_q, cnt_d;
    logic [PERIOD_W-1:0]  period_q, period_d;
    logic                 dir_q, dir_d;
    logic                 half_q, half_d;
    logic [3:0]           coil_q, coil_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 fault_q, fault_d;
    logic                 ready_q, ready_d;
    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;

    logic [2:0]           stride;
    logic [2:0]           idx_next;
    logic [PERIOD_W-1:0]  eff_period;

    // Full-step only ever rests on odd (two-coil) entries; an even start takes a single half-step to get there.
    assign stride     = (half_q || !idx_q[0]) ? 3'd1 : 3'd2;
    assign idx_next   = dir_q ? (idx_q + stride) : (idx_q - stride);
    assign eff_period = (cmd_period < PERIOD_W'(2)) ? PERIOD_W'(2) : cmd_period;

    always_comb begin
        // NOTE: every _d gets a default before any branch so no path leaves it unassigned and infers a latch.
        state_d  = state_q;
        idx_d    = idx_q;
        pos_d    = pos_q;
        steps_d  = steps_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        dir_d    = dir_q;
        half_d   = half_q;
        done_d   = 1'b0;
        sync1_d  = fault_n;
        sync2_d  = sync1_q;

        if (!sync2_q) begin
            state_d = S_FAULT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && ready_q) begin
                        dir_d    = cmd_dir;
                        half_d   = half_step;
                        period_d = eff_period;
                        cnt_d    = eff_period;
                        steps_d  = cmd_steps;
                        if (cmd_steps == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // Abort outranks a coincident period expiry, so no step is taken on that edge.
                    if (abort || steps_q == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else if (cnt_q <= PERIOD_W'(1)) begin
                        idx_d   = idx_next;
                        steps_d = steps_q - STEPS_W'(1);
                        pos_d   = dir_q ? (pos_q + 32'sd1) : (pos_q - 32'sd1);
                        cnt_d   = period_q;
                    end else begin
                        cnt_d = cnt_q - PERIOD_W'(1);
                    end
                end
                S_FAULT: begin
                    if (fault_clear) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        case (state_d)
            S_RUN:   coil_d = phase_of(idx_d);
            S_IDLE:  coil_d = hold_en ? phase_of(idx_d) : 4'b0000;
            default: coil_d = 4'b0000;
        endcase
        busy_d  = (state_d == S_RUN);
        fault_d = (state_d == S_FAULT);
        ready_d = (state_d == S_IDLE);
    end

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset) begin
            state_q  <= S_IDLE;
            idx_q    <= 3'd0;
            pos_q    <= 32'sd0;
            steps_q  <= '0;
            cnt_q    <= '0;
            period_q <= '0;
            dir_q    <= 1'b0;
            half_q   <= 1'b0;
            coil_q   <= 4'b0000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
            ready_q  <= 1'b0;
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            pos_q    <= pos_d;
            steps_q  <= steps_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            dir_q    <= dir_d;
            half_q   <= half_d;
            coil_q   <= coil_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
            ready_q  <= ready_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
        end
    end

    assign AX         = coil_q[3];
    assign AY         = coil_q[2];
    assign BX         = coil_q[1];
    assign BY         = coil_q[0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign fault      = fault_q;
    assign cmd_ready  = ready_q;
    assign steps_left = steps_q;
    assign position   = pos_q;

endmodule
